// File: rtl/ctrl_pipe_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_tracker_pkg
// Shared constants for the pipeline control tracker: PC source, write-back
// address source and write-back data source encodings (same values as the
// MIPS core's define set), plus the layout of the per-stage control bundle.
//
// Bundle layout (LSB first):
//   [ADDR_W-1:0]  regw_addr
//   [ADDR_W+0]    wb_data_src
//   [ADDR_W+1]    mem_wen
//   [ADDR_W+2]    mem_ren
//   [ADDR_W+3]    wb_wen
//   [ADDR_W+4]    is_branch
//   [ADDR_W+5]    valid
// ---------------------------------------------------------------------------
package ctrl_pipe_tracker_pkg;

  // PC source select; anything other than PC_NEXT is a taken-path candidate
  localparam logic [2:0] PC_NEXT = 3'd0;
  localparam logic [2:0] PC_JUMP = 3'd1;
  localparam logic [2:0] PC_JR   = 3'd2;
  localparam logic [2:0] PC_BEQ  = 3'd3;
  localparam logic [2:0] PC_BNE  = 3'd4;

  // Destination register select; encoding 3 is reserved and means "no write"
  typedef enum logic [1:0] {
    WB_ADDR_RD   = 2'd0,
    WB_ADDR_RT   = 2'd1,
    WB_ADDR_LINK = 2'd2,
    WB_ADDR_RSVD = 2'd3
  } wb_addr_sel_e;

  // Write-back data select
  localparam logic WB_DATA_ALU = 1'b0;
  localparam logic WB_DATA_MEM = 1'b1;

  // Link register used by JAL/JALR
  localparam int unsigned LINK_REG = 31;

  // Number of single-bit control flags carried next to regw_addr
  localparam int unsigned BUNDLE_FLAG_W = 6;

  // Flag offsets relative to the top of the address field
  localparam int unsigned OFS_WDS = 0;
  localparam int unsigned OFS_MWE = 1;
  localparam int unsigned OFS_MRE = 2;
  localparam int unsigned OFS_WEN = 3;
  localparam int unsigned OFS_BR  = 4;
  localparam int unsigned OFS_VLD = 5;

  // Total bundle width for a given register address width
  function automatic int unsigned bundle_w(input int unsigned addr_w);
    return addr_w + BUNDLE_FLAG_W;
  endfunction

endpackage

// File: rtl/ctrl_pipe_tracker_stage_reg.sv
// ---------------------------------------------------------------------------
// ctrl_stage_reg
// One pipeline stage's control bundle register. Priority, highest first:
// global reset (rst_n low), stage clear (clr), load (en), hold.
//
// Ports:
//   clk    in   1   main clock
//   rst_n  in   1   synchronous reset, active-low
//   clr    in   1   stage clear from the controller
//   en     in   1   stage load enable from the controller
//   d      in   W   bundle from the upstream stage
//   q      out  W   registered bundle
// ---------------------------------------------------------------------------
module ctrl_stage_reg
  import ctrl_pipe_tracker_pkg::*;
#(
  parameter int unsigned W = bundle_w(5)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] bundle_d;
  logic [W-1:0] bundle_q;

  // Clear beats load when the controller asserts both
  always_comb begin
    bundle_d = bundle_q;
    if (clr) begin
      bundle_d = '0;
    end else if (en) begin
      bundle_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bundle_q <= '0;
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign q = bundle_q;

endmodule

// File: rtl/ctrl_pipe_tracker.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_tracker
// Responder side of the controller's per-stage rst/en/valid protocol for the
// 5-stage MIPS CPU. Decodes the ID-stage control bundle, carries it through
// EXE, MEM and WB registers, and returns hazard feedback and stage valids.
//
// Optional feature macro: CTRL_PERF_CNT_EN adds retired/bubble/flush
// performance counters and their output ports.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   id_valid, inst                  ID-stage instruction and its valid flag
//   pc_src, wb_addr_src             decoded PC source / destination select
//   wb_data_src, wb_wen             decoded write-back select / enable
//   mem_ren, mem_wen                decoded memory enables
//   {exe,mem,wb}_rst, _en           per-stage clear / load from controller
//   {exe,mem,wb}_valid              stage valid flags
//   is_branch_exe, is_branch_mem    stage holds a jump/branch
//   regw_addr_{exe,mem,wb}          destination register (0 when no write)
//   wb_wen_{exe,mem,wb}             register write enable, valid-gated
//   mem_ren_mem, mem_wen_mem        MEM-stage memory enables, valid-gated
//   wb_data_src_wb                  WB mux select
//   perf_retired/bubbles/flushes    counters (CTRL_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ctrl_pipe_tracker
  import ctrl_pipe_tracker_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       inst,
  input  logic [2:0]        pc_src,
  input  logic [1:0]        wb_addr_src,
  input  logic              wb_data_src,
  input  logic              wb_wen,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic              exe_rst,
  input  logic              exe_en,
  input  logic              mem_rst,
  input  logic              mem_en,
  input  logic              wb_rst,
  input  logic              wb_en,
  output logic              exe_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic              is_branch_exe,
  output logic              is_branch_mem,
  output logic [ADDR_W-1:0] regw_addr_exe,
  output logic [ADDR_W-1:0] regw_addr_mem,
  output logic [ADDR_W-1:0] regw_addr_wb,
  output logic              wb_wen_exe,
  output logic              wb_wen_mem,
  output logic              wb_wen_wb,
  output logic              mem_ren_mem,
  output logic              mem_wen_mem,
  output logic              wb_data_src_wb
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_retired,
  output logic [CNT_W-1:0]  perf_bubbles,
  output logic [CNT_W-1:0]  perf_flushes
`endif
);

  localparam int unsigned BW    = bundle_w(ADDR_W);
  localparam int unsigned I_WDS = ADDR_W + OFS_WDS;
  localparam int unsigned I_MWE = ADDR_W + OFS_MWE;
  localparam int unsigned I_MRE = ADDR_W + OFS_MRE;
  localparam int unsigned I_WEN = ADDR_W + OFS_WEN;
  localparam int unsigned I_BR  = ADDR_W + OFS_BR;
  localparam int unsigned I_VLD = ADDR_W + OFS_VLD;

  logic [ADDR_W-1:0] id_regw_addr;
  logic              id_wen;
  logic [BW-1:0]     id_bundle;
  logic [BW-1:0]     exe_bundle;
  logic [BW-1:0]     mem_bundle;
  logic [BW-1:0]     wb_bundle;

  // ---- ID decode ----------------------------------------------------------
  // The reserved select and any non-writing instruction report register 0,
  // so downstream hazard logic never sees a phantom destination.
  always_comb begin
    id_regw_addr = '0;
    id_wen       = wb_wen;
    case (wb_addr_sel_e'(wb_addr_src))
      WB_ADDR_RD:   id_regw_addr = ADDR_W'(inst[15:11]);
      WB_ADDR_RT:   id_regw_addr = ADDR_W'(inst[20:16]);
      WB_ADDR_LINK: id_regw_addr = ADDR_W'(LINK_REG);
      default:      id_wen       = 1'b0;
    endcase
    if (!id_wen) begin
      id_regw_addr = '0;
    end
  end

  assign id_bundle = {id_valid, (pc_src != PC_NEXT), id_wen,
                      mem_ren, mem_wen, wb_data_src, id_regw_addr};

  // ---- ID -> EXE ----------------------------------------------------------
  ctrl_stage_reg #(.W(BW)) u_exe_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (exe_rst),
    .en    (exe_en),
    .d     (id_bundle),
    .q     (exe_bundle)
  );

  // ---- EXE -> MEM ---------------------------------------------------------
  ctrl_stage_reg #(.W(BW)) u_mem_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mem_rst),
    .en    (mem_en),
    .d     (exe_bundle),
    .q     (mem_bundle)
  );

  // ---- MEM -> WB ----------------------------------------------------------
  ctrl_stage_reg #(.W(BW)) u_wb_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wb_rst),
    .en    (wb_en),
    .d     (mem_bundle),
    .q     (wb_bundle)
  );

  // ---- Output gating ------------------------------------------------------
  // Every hazard-bearing flag is qualified by its stage valid so that a
  // bubble or squashed slot can never stall or forward.
  assign exe_valid      = exe_bundle[I_VLD];
  assign mem_valid      = mem_bundle[I_VLD];
  assign wb_valid       = wb_bundle[I_VLD];

  assign is_branch_exe  = exe_bundle[I_BR] & exe_valid;
  assign is_branch_mem  = mem_bundle[I_BR] & mem_valid;

  assign wb_wen_exe     = exe_bundle[I_WEN] & exe_valid;
  assign wb_wen_mem     = mem_bundle[I_WEN] & mem_valid;
  assign wb_wen_wb      = wb_bundle[I_WEN] & wb_valid;

  assign regw_addr_exe  = wb_wen_exe ? exe_bundle[ADDR_W-1:0] : '0;
  assign regw_addr_mem  = wb_wen_mem ? mem_bundle[ADDR_W-1:0] : '0;
  assign regw_addr_wb   = wb_wen_wb  ? wb_bundle[ADDR_W-1:0]  : '0;

  assign mem_ren_mem    = mem_bundle[I_MRE] & mem_valid;
  assign mem_wen_mem    = mem_bundle[I_MWE] & mem_valid;

  assign wb_data_src_wb = wb_bundle[I_WDS];

  // Fields carried for uniformity but not consumed at these stages
  logic unused_fields;
  assign unused_fields = ^{inst[31:21], inst[10:0],
                           exe_bundle[I_WDS], exe_bundle[I_MWE], exe_bundle[I_MRE],
                           mem_bundle[I_WDS],
                           wb_bundle[I_BR], wb_bundle[I_MWE], wb_bundle[I_MRE]};

`ifdef CTRL_PERF_CNT_EN
  // ---- Performance counters -----------------------------------------------
  // flushes counts every cycle a valid ID instruction is held back by
  // exe_en=0 (not a distinct-instruction count). All counters wrap.
  logic [CNT_W-1:0] retired_d, retired_q;
  logic [CNT_W-1:0] bubbles_d, bubbles_q;
  logic [CNT_W-1:0] flushes_d, flushes_q;

  always_comb begin
    retired_d = retired_q;
    bubbles_d = bubbles_q;
    flushes_d = flushes_q;
    if (wb_en && wb_valid && !wb_rst) begin
      retired_d = retired_q + 1'b1;
    end
    if (exe_rst) begin
      bubbles_d = bubbles_q + 1'b1;
    end
    if (id_valid && !exe_en && !exe_rst) begin
      flushes_d = flushes_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      retired_q <= retired_d;
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_bubbles = bubbles_q;
  assign perf_flushes = flushes_q;
`else
  // CNT_W only sizes the optional counters
  if (CNT_W == 0) begin : g_no_counters
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_tracker.sv
module tb_ctrl_pipe_tracker;
  import ctrl_pipe_tracker_pkg::*;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [31:0]       inst;
  logic [2:0]        pc_src;
  logic [1:0]        wb_addr_src;
  logic              wb_data_src;
  logic              wb_wen;
  logic              mem_ren, mem_wen;
  logic              exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
  logic              exe_valid, mem_valid, wb_valid;
  logic              is_branch_exe, is_branch_mem;
  logic [ADDR_W-1:0] regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic              wb_wen_exe, wb_wen_mem, wb_wen_wb;
  logic              mem_ren_mem, mem_wen_mem, wb_data_src_wb;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0]  perf_retired, perf_bubbles, perf_flushes;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe_tracker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .inst           (inst),
    .pc_src         (pc_src),
    .wb_addr_src    (wb_addr_src),
    .wb_data_src    (wb_data_src),
    .wb_wen         (wb_wen),
    .mem_ren        (mem_ren),
    .mem_wen        (mem_wen),
    .exe_rst        (exe_rst),
    .exe_en         (exe_en),
    .mem_rst        (mem_rst),
    .mem_en         (mem_en),
    .wb_rst         (wb_rst),
    .wb_en          (wb_en),
    .exe_valid      (exe_valid),
    .mem_valid      (mem_valid),
    .wb_valid       (wb_valid),
    .is_branch_exe  (is_branch_exe),
    .is_branch_mem  (is_branch_mem),
    .regw_addr_exe  (regw_addr_exe),
    .regw_addr_mem  (regw_addr_mem),
    .regw_addr_wb   (regw_addr_wb),
    .wb_wen_exe     (wb_wen_exe),
    .wb_wen_mem     (wb_wen_mem),
    .wb_wen_wb      (wb_wen_wb),
    .mem_ren_mem    (mem_ren_mem),
    .mem_wen_mem    (mem_wen_mem),
    .wb_data_src_wb (wb_data_src_wb)
`ifdef CTRL_PERF_CNT_EN
    ,
    .perf_retired   (perf_retired),
    .perf_bubbles   (perf_bubbles),
    .perf_flushes   (perf_flushes)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    id_valid    = 1'b0;
    inst        = 32'h0;
    pc_src      = PC_NEXT;
    wb_addr_src = WB_ADDR_RD;
    wb_data_src = WB_DATA_ALU;
    wb_wen      = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
  endtask

  task automatic drive_add(input logic [4:0] rd);
    drive_nop();
    id_valid    = 1'b1;
    inst        = {6'h00, 5'd1, 5'd2, rd, 5'd0, 6'h20};
    wb_addr_src = WB_ADDR_RD;
    wb_wen      = 1'b1;
  endtask

  task automatic drive_jal();
    drive_nop();
    id_valid    = 1'b1;
    inst        = {6'h03, 26'h0000100};
    pc_src      = PC_JUMP;
    wb_addr_src = WB_ADDR_LINK;
    wb_wen      = 1'b1;
  endtask

  task automatic drive_lw(input logic [4:0] rt);
    drive_nop();
    id_valid    = 1'b1;
    inst        = {6'h23, 5'd1, rt, 16'h0010};
    wb_addr_src = WB_ADDR_RT;
    wb_data_src = WB_DATA_MEM;
    wb_wen      = 1'b1;
    mem_ren     = 1'b1;
  endtask

  initial begin
    // Reset with every stage enabled and a real instruction at ID
    rst_n   = 1'b0;
    exe_rst = 1'b0; mem_rst = 1'b0; wb_rst = 1'b0;
    exe_en  = 1'b1; mem_en  = 1'b1; wb_en  = 1'b1;
    drive_add(5'd5);
    step();
    chk("rst_exe_valid", 32'(exe_valid), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_wb_valid",  32'(wb_valid), 0);
    chk("rst_wen_exe",   32'(wb_wen_exe), 0);
    chk("rst_wen_wb",    32'(wb_wen_wb), 0);
    chk("rst_br_exe",    32'(is_branch_exe), 0);
    chk("rst_addr_exe",  32'(regw_addr_exe), 0);

    // ADD rd=5 through the pipe
    rst_n = 1'b1;
    drive_add(5'd5);
    step();
    chk("add_exe_valid", 32'(exe_valid), 1);
    chk("add_addr_exe",  32'(regw_addr_exe), 5);
    chk("add_wen_exe",   32'(wb_wen_exe), 1);
    drive_nop();
    step();
    chk("add_addr_mem",  32'(regw_addr_mem), 5);
    chk("add_wen_mem",   32'(wb_wen_mem), 1);
    chk("nop_exe_valid", 32'(exe_valid), 0);
    step();
    chk("add_wen_wb",    32'(wb_wen_wb), 1);
    chk("add_addr_wb",   32'(regw_addr_wb), 5);
    chk("nop_mem_valid", 32'(mem_valid), 0);

    // JAL: branch flag and link register
    drive_jal();
    step();
    chk("jal_br_exe",    32'(is_branch_exe), 1);
    chk("jal_addr_exe",  32'(regw_addr_exe), 31);
    drive_nop();
    step();
    chk("jal_br_mem",    32'(is_branch_mem), 1);
    chk("jal_addr_mem",  32'(regw_addr_mem), 31);
    chk("nop_br_exe",    32'(is_branch_exe), 0);

    // Reserved wb_addr_src encoding forces no write
    drive_add(5'd7);
    wb_addr_src = 2'd3;
    step();
    chk("rsv_exe_valid", 32'(exe_valid), 1);
    chk("rsv_wen_exe",   32'(wb_wen_exe), 0);
    chk("rsv_addr_exe",  32'(regw_addr_exe), 0);

    // Invalid ID slot with write decoded must not report a hazard
    drive_add(5'd9);
    id_valid = 1'b0;
    step();
    chk("inv_wen_exe",   32'(wb_wen_exe), 0);
    chk("inv_addr_exe",  32'(regw_addr_exe), 0);
    chk("rsv_wen_mem",   32'(wb_wen_mem), 0);

    // Bubble: exe_rst together with exe_en clears EXE; MEM takes old EXE
    drive_add(5'd6);
    step();
    exe_rst = 1'b1;
    drive_add(5'd12);
    step();
    chk("bub_exe_valid", 32'(exe_valid), 0);
    chk("bub_wen_exe",   32'(wb_wen_exe), 0);
    chk("bub_mem_valid", 32'(mem_valid), 1);
    chk("bub_addr_mem",  32'(regw_addr_mem), 6);
    exe_rst = 1'b0;

    // Hold: LW parked in MEM for two cycles with mem_en=0
    drive_lw(5'd8);
    step();
    drive_nop();
    step();
    chk("lw_ren_mem",    32'(mem_ren_mem), 1);
    chk("lw_addr_mem",   32'(regw_addr_mem), 8);
    mem_en = 1'b0;
    drive_add(5'd10);
    step();
    chk("hold1_ren_mem", 32'(mem_ren_mem), 1);
    chk("hold1_addr_mem",32'(regw_addr_mem), 8);
    chk("hold1_addr_wb", 32'(regw_addr_wb), 8);
    chk("hold1_wds_wb",  32'(wb_data_src_wb), 1);
    drive_nop();
    step();
    chk("hold2_ren_mem", 32'(mem_ren_mem), 1);
    chk("hold2_addr_mem",32'(regw_addr_mem), 8);
    chk("hold2_exe_ovw", 32'(exe_valid), 0);
    mem_en = 1'b1;

    // wb_rst and wb_en together: clear wins
    wb_rst = 1'b1;
    step();
    chk("wbclr_valid",   32'(wb_valid), 0);
    chk("wbclr_wen",     32'(wb_wen_wb), 0);
    chk("wbclr_mem_vld", 32'(mem_valid), 0);
    wb_rst = 1'b0;

    // Mid-operation reset clears all stages at once
    drive_add(5'd3);
    step();
    drive_add(5'd4);
    step();
    chk("pre_mem_addr",  32'(regw_addr_mem), 3);
    rst_n = 1'b0;
    step();
    chk("mid_exe_valid", 32'(exe_valid), 0);
    chk("mid_mem_valid", 32'(mem_valid), 0);
    chk("mid_wb_valid",  32'(wb_valid), 0);
    rst_n = 1'b1;
    drive_nop();

`ifdef CTRL_PERF_CNT_EN
    chk("perf_rst_ret",  32'(perf_retired), 0);
    chk("perf_rst_bub",  32'(perf_bubbles), 0);
    chk("perf_rst_fl",   32'(perf_flushes), 0);
    for (int i = 0; i < 4; i++) begin
      drive_add(5'(i + 1));
      step();
    end
    drive_nop();
    for (int i = 0; i < 4; i++) begin
      step();
    end
    chk("perf_ret4",     32'(perf_retired), 4);
    exe_rst = 1'b1;
    step();
    step();
    exe_rst = 1'b0;
    chk("perf_bub2",     32'(perf_bubbles), 2);
    chk("perf_ret_hold", 32'(perf_retired), 4);
    chk("perf_fl0",      32'(perf_flushes), 0);
    exe_en = 1'b0;
    drive_add(5'd1);
    step();
    chk("perf_fl1",      32'(perf_flushes), 1);
    exe_en = 1'b1;
    drive_nop();
    exe_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    chk("perf_bub_max",  32'(perf_bubbles), 7);
    step();
    chk("perf_bub_wrap", 32'(perf_bubbles), 0);
    exe_rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
